// File: rtl/pe_access_sequencer.sv
// Per-PE control-word sequencer for the local store controller and MAC strobes; PE_SEQ_ABORT_EN adds an abort input.
// First word one cycle after start is accepted in IDLE; no backpressure, start is ignored until the sequencer is back in IDLE.
module pe_access_sequencer #(
   parameter int depth  = 2,
   parameter int A      = 7,
   parameter int CTR_IP = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [A-1:0]      loadLen,
   input  logic [A-1:0]      kRows,
   input  logic [A-1:0]      kCols,
   input  logic [depth-1:0]  kRowOfst,
   input  logic [depth-1:0]  kColOfst,
   input  logic [depth-1:0]  nRowOfst,
   input  logic [depth-1:0]  nColOfst,
`ifdef PE_SEQ_ABORT_EN
   input  logic              abort,
`endif
   output logic [CTR_IP-1:0] controlSignal,
   output logic [depth-1:0]  initSettings,
   output logic              macValid,
   output logic              accClear,
   output logic              busy,
   output logic              done
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_SKR  = 4'd1;
   localparam logic [3:0] S_SKC  = 4'd2;
   localparam logic [3:0] S_SNR  = 4'd3;
   localparam logic [3:0] S_SNC  = 4'd4;
   localparam logic [3:0] S_INIT = 4'd5;
   localparam logic [3:0] S_RUN  = 4'd6;
   localparam logic [3:0] S_JMP  = 4'd7;
   localparam logic [3:0] S_DONE = 4'd8;

   localparam logic [1:0] M_LDK = 2'b00;
   localparam logic [1:0] M_LDN = 2'b01;
   localparam logic [1:0] M_CMP = 2'b10;

   logic [3:0]         state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [A-1:0]       col_lim_q, col_lim_d, row_lim_q, row_lim_d;
   logic [A-1:0]       col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
   logic [4*depth-1:0] ofs_q, ofs_d;
   logic               col_last, row_last;

   logic [CTR_IP-1:0]  ctl_d;
   logic [depth-1:0]   init_d;
   logic               mac_d, acc_d, done_d;

   assign col_last = (col_cnt_q == col_lim_q - A'(1));
   assign row_last = (row_cnt_q == row_lim_q - A'(1));

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      col_lim_d = col_lim_q;
      row_lim_d = row_lim_q;
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      ofs_d     = ofs_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Everything the operation needs is captured here so later input changes are harmless.
               mode_d    = mode;
               col_lim_d = (mode == M_CMP) ? kCols : loadLen;
               row_lim_d = kRows;
               ofs_d     = {nColOfst, nRowOfst, kColOfst, kRowOfst};
               col_cnt_d = '0;
               row_cnt_d = '0;
               case (mode)
                  M_LDK, M_LDN: state_d = S_INIT;
                  M_CMP:        state_d = S_SKR;
                  default:      state_d = S_DONE;
               endcase
            end
         end
         S_SKR: state_d = S_SKC;
         S_SKC: state_d = S_SNR;
         S_SNR: state_d = S_SNC;
         S_SNC: state_d = S_INIT;
         S_INIT: begin
            col_cnt_d = '0;
            row_cnt_d = '0;
            if (col_lim_q == '0 || (mode_q == M_CMP && row_lim_q == '0))
               state_d = S_DONE;
            else
               state_d = S_RUN;
         end
         S_RUN: begin
            if (col_last) begin
               col_cnt_d = '0;
               if (mode_q != M_CMP || row_last)
                  state_d = S_DONE;
               else
                  state_d = S_JMP;
            end else begin
               col_cnt_d = col_cnt_q + A'(1);
            end
         end
         S_JMP: begin
            row_cnt_d = row_cnt_q + A'(1);
            state_d   = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef PE_SEQ_ABORT_EN
      if (abort && state_q != S_IDLE && state_q != S_DONE)
         state_d = S_DONE;
`endif
   end

   // Outputs are decoded from the next state and registered, so they line up with state_q.
   always_comb begin
      ctl_d  = CTR_IP'(8'h22);
      init_d = '0;
      mac_d  = 1'b0;
      acc_d  = 1'b0;
      done_d = 1'b0;
      case (state_d)
         S_SKR: begin ctl_d = CTR_IP'(8'h82); init_d = ofs_d[0*depth +: depth]; end
         S_SKC: begin ctl_d = CTR_IP'(8'hA2); init_d = ofs_d[1*depth +: depth]; end
         S_SNR: begin ctl_d = CTR_IP'(8'h2C); init_d = ofs_d[2*depth +: depth]; end
         S_SNC: begin ctl_d = CTR_IP'(8'h2E); init_d = ofs_d[3*depth +: depth]; end
         S_INIT: begin
            if (mode_d == M_LDK)      ctl_d = CTR_IP'(8'h02);
            else if (mode_d == M_LDN) ctl_d = CTR_IP'(8'h20);
            else begin
               ctl_d = CTR_IP'(8'h00);
               acc_d = 1'b1;
            end
         end
         S_RUN: begin
            if (mode_d == M_LDK)      ctl_d = CTR_IP'(8'h52);
            else if (mode_d == M_LDN) ctl_d = CTR_IP'(8'h25);
            else begin
               ctl_d = CTR_IP'(8'h44);
               mac_d = 1'b1;
            end
         end
         S_JMP:  ctl_d  = CTR_IP'(8'h66);
         S_DONE: done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= S_IDLE;
         mode_q        <= '0;
         col_lim_q     <= '0;
         row_lim_q     <= '0;
         col_cnt_q     <= '0;
         row_cnt_q     <= '0;
         ofs_q         <= '0;
         controlSignal <= CTR_IP'(8'h22);
         initSettings  <= '0;
         macValid      <= 1'b0;
         accClear      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         col_lim_q     <= col_lim_d;
         row_lim_q     <= row_lim_d;
         col_cnt_q     <= col_cnt_d;
         row_cnt_q     <= row_cnt_d;
         ofs_q         <= ofs_d;
         controlSignal <= ctl_d;
         initSettings  <= init_d;
         macValid      <= mac_d;
         accClear      <= acc_d;
         busy          <= (state_d != S_IDLE);
         done          <= done_d;
      end
   end

endmodule

// File: tb/tb_pe_access_sequencer.sv
// Randomized and directed bench for pe_access_sequencer against a per-operation expected-word model.
module tb_pe_access_sequencer;
   localparam int depth = 2;
   localparam int A     = 7;

   logic             CLK = 1'b0;
   logic             RST;
   logic             start;
   logic [1:0]       mode;
   logic [A-1:0]     loadLen, kRows, kCols;
   logic [depth-1:0] kRowOfst, kColOfst, nRowOfst, nColOfst;
`ifdef PE_SEQ_ABORT_EN
   logic             abort;
`endif
   logic [7:0]       controlSignal;
   logic [depth-1:0] initSettings;
   logic             macValid, accClear, busy, done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [13:0] exp_q[$];

   pe_access_sequencer #(.depth(depth), .A(A), .CTR_IP(8)) dut (
      .CLK(CLK), .RST(RST), .start(start), .mode(mode),
      .loadLen(loadLen), .kRows(kRows), .kCols(kCols),
      .kRowOfst(kRowOfst), .kColOfst(kColOfst), .nRowOfst(nRowOfst), .nColOfst(nColOfst),
`ifdef PE_SEQ_ABORT_EN
      .abort(abort),
`endif
      .controlSignal(controlSignal), .initSettings(initSettings),
      .macValid(macValid), .accClear(accClear), .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   // Packed view: {busy, done, accClear, macValid, initSettings, controlSignal}
   function automatic logic [13:0] word(input logic [7:0] ctl, input logic [1:0] ini,
                                        input logic mac, input logic acc, input logic dn, input logic bsy);
      return {bsy, dn, acc, mac, ini, ctl};
   endfunction

   function automatic logic [13:0] obs();
      return {busy, done, accClear, macValid, initSettings, controlSignal};
   endfunction

   task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic scramble();
      mode     = 2'($urandom);
      loadLen  = A'($urandom);
      kRows    = A'($urandom);
      kCols    = A'($urandom);
      kRowOfst = 2'($urandom);
      kColOfst = 2'($urandom);
      nRowOfst = 2'($urandom);
      nColOfst = 2'($urandom);
   endtask

   task automatic build(input logic [1:0] m, input int len, input int rows, input int cols,
                        input logic [1:0] o0, input logic [1:0] o1, input logic [1:0] o2, input logic [1:0] o3);
      exp_q.delete();
      case (m)
         2'b00: begin
            exp_q.push_back(word(8'h02, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
            for (int k = 0; k < len; k++) exp_q.push_back(word(8'h52, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
         end
         2'b01: begin
            exp_q.push_back(word(8'h20, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
            for (int k = 0; k < len; k++) exp_q.push_back(word(8'h25, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
         end
         2'b10: begin
            exp_q.push_back(word(8'h82, o0, 1'b0, 1'b0, 1'b0, 1'b1));
            exp_q.push_back(word(8'hA2, o1, 1'b0, 1'b0, 1'b0, 1'b1));
            exp_q.push_back(word(8'h2C, o2, 1'b0, 1'b0, 1'b0, 1'b1));
            exp_q.push_back(word(8'h2E, o3, 1'b0, 1'b0, 1'b0, 1'b1));
            exp_q.push_back(word(8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1));
            if (rows > 0 && cols > 0)
               for (int r = 0; r < rows; r++) begin
                  for (int c = 0; c < cols; c++) exp_q.push_back(word(8'h44, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1));
                  if (r < rows - 1) exp_q.push_back(word(8'h66, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
               end
         end
         default: ;
      endcase
      exp_q.push_back(word(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
   endtask

   // rst_at >= 0 asserts RST (together with start) during that cycle of the operation.
   task automatic run_op(input logic [1:0] m, input int len, input int rows, input int cols,
                         input logic [1:0] o0, input logic [1:0] o1, input logic [1:0] o2, input logic [1:0] o3,
                         input int rst_at, input string tag);
      build(m, len, rows, cols, o0, o1, o2, o3);
      @(negedge CLK);
      start = 1'b1; mode = m;
      loadLen = A'(len); kRows = A'(rows); kCols = A'(cols);
      kRowOfst = o0; kColOfst = o1; nRowOfst = o2; nColOfst = o3;
      @(posedge CLK);
      #1;
      start = 1'b0;
      scramble();
      foreach (exp_q[i]) begin
         @(negedge CLK);
         chk($sformatf("%s[%0d]", tag, i), obs(), exp_q[i]);
         if (i == rst_at) begin
            RST = 1'b1;
            start = 1'b1;
            @(posedge CLK);
            #1;
            RST = 1'b0;
            start = 1'b0;
            @(negedge CLK);
            chk({tag, "_rst_idle"}, obs(), word(8'h22, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
            return;
         end
         start = 1'($urandom);
         scramble();
      end
      @(negedge CLK);
      start = 1'b0;
      chk({tag, "_idle"}, obs(), word(8'h22, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
   endtask

   initial begin
      logic [13:0] held[5];
      RST = 1'b1;
      start = 1'b0;
`ifdef PE_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      mode = 2'b00; loadLen = '0; kRows = '0; kCols = '0;
      kRowOfst = '0; kColOfst = '0; nRowOfst = '0; nColOfst = '0;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         chk($sformatf("reset_idle[%0d]", k), obs(), word(8'h22, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      end

      run_op(2'b00, 4, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, -1, "ldk4");
      run_op(2'b10, 0, 2, 3, 2'd1, 2'd2, 2'd3, 2'd0, -1, "cmp2x3");
      run_op(2'b10, 0, 2, 0, 2'd3, 2'd1, 2'd2, 2'd1, -1, "cmp_kcols0");
      run_op(2'b10, 0, 0, 3, 2'd2, 2'd2, 2'd1, 2'd3, -1, "cmp_krows0");
      run_op(2'b00, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, -1, "ldk0");
      run_op(2'b11, 5, 2, 2, 2'd1, 2'd1, 2'd1, 2'd1, -1, "nop");
      run_op(2'b10, 0, 2, 3, 2'd1, 2'd2, 2'd3, 2'd0, 6, "cmp_rst");
      run_op(2'b01, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, -1, "ldn1");
      run_op(2'b10, 0, 1, 1, 2'd3, 2'd3, 2'd3, 2'd3, -1, "cmp1x1");

      held[0] = word(8'h02, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      held[1] = word(8'h52, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      held[2] = word(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      held[3] = word(8'h22, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      held[4] = word(8'h02, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge CLK);
      start = 1'b1; mode = 2'b00; loadLen = A'(1);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk($sformatf("held_start[%0d]", k), obs(), held[k]);
      end
      start = 1'b0;
      repeat (3) @(negedge CLK);
      chk("held_drain", obs(), word(8'h22, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      for (int t = 0; t < 40; t++) begin
         logic [1:0] m;
         m = 2'($urandom);
         run_op(m, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), -1, $sformatf("rnd%0d_m%0d", t, m));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
